proc_elem_mac: RTL and testbench

Parametrised fixed-point processing element for the MMM systolic array: successor to the single-mode PE, adding configurable widths and a pipelined multiply-accumulate. It forwards top/left operands and control to its down/right neighbours one cycle later and accumulates signed products over framed dot products. Completed results are held in a one-entry valid/ready result register, together with a rounded, saturated DATA_W copy.

---
 rtl/proc_elem_mac.sv | 146 ++++++++++++++
 tb/tb_proc_elem_mac.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_elem_mac.sv
// proc_elem_mac: systolic-array processing element. Forwards operands and
// framing control to the down/right neighbours one cycle late, multiplies
// in stage 1, accumulates with saturation in stage 2, and parks completed
// dot products in a one-entry valid/ready result register.
module proc_elem_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] top,
  input  logic [DATA_W-1:0] left,
  input  logic              valid_in,
  input  logic              first_in,
  input  logic              last_in,
  output logic [DATA_W-1:0] down,
  output logic [DATA_W-1:0] right,
  output logic              valid_out,
  output logic              first_out,
  output logic              last_out,
  output logic [ACC_W-1:0]  res,
  output logic [DATA_W-1:0] res_q,
  output logic              res_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_lost
);
  localparam int PW = 2 * DATA_W;

  // stage-1 product tagged with its framing bits
  typedef struct packed {
    logic          first;
    logic          last;
    logic [PW-1:0] p;
  } prod_t;

  prod_t             prod;
  logic              p_v;
  logic [ACC_W-1:0]  acc;
  logic              ovf;

  logic [PW-1:0]     prod_c;
  logic [ACC_W:0]    base, addend, wide;
  logic              sat_hi, sat_lo, ovf_n;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W:0]    rnd, shifted;
  logic [DATA_W-1:0] q_c;
  logic              load, pop;

  // operands sign-extended to the full product width before multiplying
  assign prod_c = {{DATA_W{top[DATA_W-1]}}, top} * {{DATA_W{left[DATA_W-1]}}, left};

  // forward operands/control and register the tagged product
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      down      <= '0;
      right     <= '0;
      valid_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      prod      <= '0;
      p_v       <= 1'b0;
    end else begin
      down      <= top;
      right     <= left;
      valid_out <= valid_in;
      first_out <= first_in;
      last_out  <= last_in;
      p_v       <= valid_in;
      if (valid_in) prod <= '{first: first_in, last: last_in, p: prod_c};
    end
  end

  // one guard bit above ACC_W detects overflow of the signed add
  always_comb begin
    addend = {{(ACC_W + 1 - PW){prod.p[PW-1]}}, prod.p};
    base   = prod.first ? '0 : {acc[ACC_W-1], acc};
    wide   = base + addend;
    sat_hi = ~wide[ACC_W] & wide[ACC_W-1];
    sat_lo = wide[ACC_W] & ~wide[ACC_W-1];
    if (sat_hi)      sum = {1'b0, {(ACC_W-1){1'b1}}};
    else if (sat_lo) sum = {1'b1, {(ACC_W-1){1'b0}}};
    else             sum = wide[ACC_W-1:0];
    ovf_n  = (prod.first ? 1'b0 : ovf) | sat_hi | sat_lo;
  end

  // sum carries 2*FRAC fractional bits; drop FRAC of them, rounding half up
  generate
    if (FRAC > 0) begin : g_rnd
      always_comb begin
        rnd     = {sum[ACC_W-1], sum} + ((ACC_W+1)'(1) << (FRAC - 1));
        shifted = $unsigned($signed(rnd) >>> FRAC);
      end
    end else begin : g_nornd
      always_comb begin
        rnd     = {sum[ACC_W-1], sum};
        shifted = rnd;
      end
    end
  endgenerate

  // clamp the rounded value into the operand range
  always_comb begin
    if (&shifted[ACC_W:DATA_W-1] || ~|shifted[ACC_W:DATA_W-1])
      q_c = shifted[DATA_W-1:0];
    else if (shifted[ACC_W])
      q_c = {1'b1, {(DATA_W-1){1'b0}}};
    else
      q_c = {1'b0, {(DATA_W-1){1'b1}}};
  end

  assign load = p_v & prod.last;
  assign pop  = res_valid & res_ready;

  // accumulator update; bubbles leave acc/ovf untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (p_v) begin
      acc <= sum;
      ovf <= ovf_n;
    end
  end

  // result register: a load beats a same-cycle pop; unread overwrite is sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res       <= '0;
      res_q     <= '0;
      res_ovf   <= 1'b0;
      res_valid <= 1'b0;
      res_lost  <= 1'b0;
    end else if (load) begin
      res       <= sum;
      res_q     <= q_c;
      res_ovf   <= ovf_n;
      res_valid <= 1'b1;
      if (res_valid & ~res_ready) res_lost <= 1'b1;
    end else if (pop) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_elem_mac.sv
// Bench for proc_elem_mac: a 40-bit and a 32-bit accumulator instance driven
// in parallel, checked every cycle against an integer model of the frame rules.
module tb_proc_elem_mac;
  localparam int DW = 16;
  localparam int FR = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] top = '0, left = '0;
  logic valid_in = 1'b0, first_in = 1'b0, last_in = 1'b0, res_ready = 1'b0;

  logic [DW-1:0] down[2], right[2], res_q[2];
  logic          vo[2], fo[2], lo[2], res_ovf[2], res_valid[2], res_lost[2];
  logic [39:0]   res40;
  logic [31:0]   res32;

  always #5 clk = ~clk;

  proc_elem_mac #(.DATA_W(DW), .ACC_W(40), .FRAC(FR)) u40 (
    .clk(clk), .reset(reset), .top(top), .left(left), .valid_in(valid_in),
    .first_in(first_in), .last_in(last_in), .down(down[0]), .right(right[0]),
    .valid_out(vo[0]), .first_out(fo[0]), .last_out(lo[0]), .res(res40),
    .res_q(res_q[0]), .res_ovf(res_ovf[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready), .res_lost(res_lost[0]));

  proc_elem_mac #(.DATA_W(DW), .ACC_W(32), .FRAC(FR)) u32 (
    .clk(clk), .reset(reset), .top(top), .left(left), .valid_in(valid_in),
    .first_in(first_in), .last_in(last_in), .down(down[1]), .right(right[1]),
    .valid_out(vo[1]), .first_out(fo[1]), .last_out(lo[1]), .res(res32),
    .res_q(res_q[1]), .res_ovf(res_ovf[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready), .res_lost(res_lost[1]));

  int n_chk = 0, n_fail = 0;

  // model state
  longint amax[2], amin[2];
  longint m_acc[2], m_res[2], m_q[2];
  bit     m_ovf[2], m_rovf[2], m_rv[2], m_lost[2];
  bit     pv, pf, pl;
  longint pp;
  longint e_down, e_right;
  bit     e_v, e_f, e_l;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint qz(input longint s);
    longint r;
    r = (s + (64'sd1 <<< (FR - 1))) >>> FR;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_res[i] = 0; m_q[i] = 0;
      m_ovf[i] = 0; m_rovf[i] = 0; m_rv[i] = 0; m_lost[i] = 0;
    end
    pv = 0; pf = 0; pl = 0; pp = 0;
    e_down = 0; e_right = 0; e_v = 0; e_f = 0; e_l = 0;
  endtask

  // one clock edge: retire the element captured last edge, then capture inputs
  task automatic model_edge();
    longint s;
    bit sat;
    if (reset) begin model_reset(); return; end
    for (int i = 0; i < 2; i++) begin
      if (pv) begin
        s = (pf ? 64'sd0 : m_acc[i]) + pp;
        sat = 0;
        if (s > amax[i]) begin s = amax[i]; sat = 1; end
        if (s < amin[i]) begin s = amin[i]; sat = 1; end
        m_acc[i] = s;
        m_ovf[i] = (pf ? 1'b0 : m_ovf[i]) | sat;
      end
      if (pv && pl) begin
        if (m_rv[i] && !res_ready) m_lost[i] = 1;
        m_res[i] = m_acc[i]; m_q[i] = qz(m_acc[i]); m_rovf[i] = m_ovf[i]; m_rv[i] = 1;
      end else if (m_rv[i] && res_ready) begin
        m_rv[i] = 0;
      end
    end
    if (valid_in) begin
      pf = first_in; pl = last_in;
      pp = longint'($signed(top)) * longint'($signed(left));
    end
    pv = valid_in;
    e_down = top; e_right = left; e_v = valid_in; e_f = first_in; e_l = last_in;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("down%0d", i), down[i], e_down);
      chk($sformatf("right%0d", i), right[i], e_right);
      chk($sformatf("ctl%0d", i), {vo[i], fo[i], lo[i]}, {e_v, e_f, e_l});
      chk($sformatf("res%0d", i), (i == 0) ? longint'($signed(res40)) : longint'($signed(res32)), m_res[i]);
      chk($sformatf("res_q%0d", i), longint'($signed(res_q[i])), m_q[i]);
      chk($sformatf("flags%0d", i), {res_ovf[i], res_valid[i], res_lost[i]}, {m_rovf[i], m_rv[i], m_lost[i]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic elem(input bit v, input bit f, input bit l, input logic [DW-1:0] t, input logic [DW-1:0] lf);
    valid_in = v; first_in = f; last_in = l; top = t; left = lf;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    amax[0] = (64'sd1 <<< 39) - 1; amin[0] = -(64'sd1 <<< 39);
    amax[1] = (64'sd1 <<< 31) - 1; amin[1] = -(64'sd1 <<< 31);
    model_reset();
    #1;
    compare_all();
    tick();
    reset = 1'b0;
    res_ready = 1'b0;

    // single element frame: 5.0 * 2.0
    elem(1, 1, 1, 16'h0500, 16'h0200);
    chk("fwd_down", down[0], 16'h0500);
    chk("fwd_right", right[0], 16'h0200);
    elem(0, 0, 0, 16'h0000, 16'h0000);
    chk("single_res", longint'($signed(res40)), 655360);
    chk("single_q", res_q[0], 16'h0A00);
    chk("single_v", {res_valid[0], res_ovf[0]}, 2'b10);
    res_ready = 1'b1;
    elem(0, 0, 0, 16'h0, 16'h0);
    chk("popped", res_valid[0], 0);

    // 3-element frame with a bubble
    elem(1, 1, 0, 16'h0500, 16'h0200);
    elem(1, 0, 0, 16'h0400, 16'h0200);
    elem(0, 1, 1, 16'h1234, 16'h4321);
    elem(1, 0, 1, 16'h9C00, 16'h6E00);
    res_ready = 1'b0;
    elem(0, 0, 0, 16'h0, 16'h0);
    chk("frame3_res", longint'($signed(res40)), -719716352);
    chk("frame3_q", res_q[0], 16'h8000);
    chk("frame3_ovf", res_ovf[0], 0);

    // 32-bit accumulator saturation, then a clean frame clears ovf
    res_ready = 1'b1;
    elem(1, 1, 0, 16'h7FFF, 16'h7FFF);
    elem(1, 0, 0, 16'h7FFF, 16'h7FFF);
    elem(1, 0, 1, 16'h7FFF, 16'h7FFF);
    elem(0, 0, 0, 16'h0, 16'h0);
    chk("sat_res", res32, 32'h7FFFFFFF);
    chk("sat_ovf", res_ovf[1], 1);
    res_ready = 1'b0;
    elem(1, 1, 1, 16'h0001, 16'h0001);
    elem(0, 0, 0, 16'h0, 16'h0);
    chk("clean_res", res32, 1);
    chk("clean_ovf", res_ovf[1], 0);

    // overwrite with consumer stalled -> sticky lost
    do_reset();
    res_ready = 1'b0;
    elem(1, 1, 1, 16'h0500, 16'h0200);
    elem(1, 1, 1, 16'h0400, 16'h0200);
    elem(0, 0, 0, 16'h0, 16'h0);
    chk("lost_res", longint'($signed(res40)), 524288);
    chk("lost_flag", res_lost[0], 1);
    // same pair, consumer ready on the second load edge -> no loss
    do_reset();
    chk("rst_lost", res_lost[0], 0);
    elem(1, 1, 1, 16'h0500, 16'h0200);
    elem(1, 1, 1, 16'h0400, 16'h0200);
    res_ready = 1'b1;
    elem(0, 0, 0, 16'h0, 16'h0);
    chk("ld_pop_v", res_valid[0], 1);
    chk("ld_pop_lost", res_lost[0], 0);
    chk("ld_pop_res", longint'($signed(res40)), 524288);

    // control pass-through
    elem(1, 1, 0, 16'h0, 16'h0);
    chk("ctl_a", {vo[0], fo[0], lo[0]}, 3'b110);
    elem(0, 0, 0, 16'h0, 16'h0);
    chk("ctl_b", {vo[0], fo[0], lo[0]}, 3'b000);
    elem(1, 0, 1, 16'h0, 16'h0);
    chk("ctl_c", {vo[0], fo[0], lo[0]}, 3'b101);

    // reset mid-stream: outputs clear asynchronously
    elem(1, 1, 0, 16'h0300, 16'h0300);
    valid_in = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_rst", {down[0], vo[0], res_valid[0], res40 != 0}, 0);
    model_reset();
    tick();
    reset = 1'b0;
    elem(1, 0, 1, 16'h0100, 16'h0100);
    elem(0, 0, 0, 16'h0, 16'h0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      res_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0)
        elem($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             {1'b0, 15'($urandom_range(16'h7000, 16'h7FFF))}, 16'h7FFF ^ 16'($urandom_range(0, 15)));
      else
        elem($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             16'($urandom), 16'($urandom));
      if (c == 300) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
